xenoa_boundary_sched: RTL and testbench
=======================================

Name: xenoa_boundary_sched

Overview:
- Shares one xenoa boundary-mapping stage among NUM_REQ temporal-semantic sources.
- Each source is bound to a boundary context held in a local config table: boundary_id, boundary_type, contract_id, sla_id, enable.
- The block runs round-robin arbitration with a per-source burst limit and issues one registered transaction per beat to the mapping stage, with valid/ready backpressure.
- It sits between the XENOS temporal qualifiers and the boundary-map stage.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- MAX_BURST, 4, maximum consecutive beats granted to one source before forced rotation (1..15).
- IDX_W, $clog2(NUM_REQ), source index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-source request valid.
- req_ready  out  NUM_REQ  per-source accept. A beat transfers when valid and ready are both high.
- req_key  in  NUM_REQ*32  time-qualified key per source.
- req_value  in  NUM_REQ*32  normalized value per source.
- req_severity  in  NUM_REQ*4  severity per source.
- req_chain  in  NUM_REQ*128  causal chain id per source.
- cfg_we  in  1  config table write strobe.
- cfg_idx  in  IDX_W  table entry written.
- cfg_boundary_id  in  16  boundary id.
- cfg_boundary_type  in  8  0 RACK, 1 CLUSTER, 2 DOMAIN, 3 TENANT.
- cfg_contract_id  in  32  contract id.
- cfg_sla_id  in  32  SLA id.
- cfg_enable  in  1  entry enable.
- map_valid  out  1  output slot holds a transaction.
- map_ready  in  1  mapping stage accepts the transaction.
- map_boundary_id  out  16  context of the granted source.
- map_boundary_type  out  8  context of the granted source.
- map_contract_id  out  32  context of the granted source.
- map_sla_id  out  32  context of the granted source.
- map_key  out  32  granted key.
- map_value  out  32  granted value.
- map_severity  out  4  granted severity.
- map_chain  out  128  granted causal chain id.
- map_src  out  IDX_W  granted source index.
- busy  out  1  map_valid or any enabled req_valid.

Behaviour:
- Reset, asynchronous and active-low:
  - All outputs 0; map_valid=0.
  - rr_ptr=0, burst_cnt=0, last_src=0.
  - All table entries cleared, including enable=0.
  - Reset mid-transfer discards the held transaction with no replay.
- Output slot: one register stage.
  - The slot is free when map_valid=0, or when map_valid and map_ready are both high (same-cycle refill allowed).
- Eligibility: source i is eligible when req_valid[i] is high and the table entry i has enable=1.
  - req_ready is never asserted for a disabled source; its requests stall indefinitely.
- Arbitration (combinational, evaluated when the slot is free):
  - If last_src is eligible, burst_cnt<MAX_BURST, and a grant occurred the previous slot-free cycle, last_src keeps the grant.
  - Otherwise grant the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
- At most one req_ready bit is high per cycle: the granted source, and only when the slot is free.
- On grant:
  - The slot loads the source payload, table context and map_src; map_valid=1 on the next edge. Latency from req_valid to map_valid is 1 cycle.
  - burst_cnt increments if the grant is the same source as the previous grant, else it becomes 1.
  - rr_ptr is set to (granted+1) mod NUM_REQ when the grant rotates or burst_cnt reaches MAX_BURST.
- Slot free with no eligible source: map_valid drops to 0 and burst_cnt is cleared.
- map_ready low with map_valid high: the slot and all map_* outputs hold stable, and every req_ready is 0.
- Config table: one write port; writes take effect on the next edge.
  - A grant in the same cycle as a write to the same entry captures the old context.
  - A transaction already in the slot is unaffected by later writes.
  - Clearing enable on last_src ends its burst at once.
- boundary_type is passed unchanged. Values above 3 are legal; the mapping stage treats them as RACK.

Decomposition:
- Package xenoa_sched_pkg:
  - typedef boundary_ctx_t, a struct of id, type, contract, sla, enable.
  - typedef sem_beat_t, a struct of key, value, severity, chain.
  - Constants BT_RACK..BT_TENANT.
- Sub-module xenoa_rr_arbiter: a parameterised round-robin priority pick from an eligibility vector and rr_ptr, with grant-one-hot and index outputs.
- The table, burst counter and output slot remain in the top.

Test Plan:
1. Round-robin rotation.
   - Stimulus: MAX_BURST=1; entries 0..3 enabled; all sources valid; map_ready=1.
   - Required: map_src sequence 0,1,2,3,0 on consecutive cycles; each map_boundary_id matches its entry (e.g. 16'h0A00+i).
2. Burst limit.
   - Stimulus: MAX_BURST=4; sources 0 and 2 valid continuously.
   - Required: map_src sequence 0,0,0,0,2,2,2,2,0.
3. Backpressure.
   - Stimulus: map_ready=0 for 5 cycles with the slot holding key 32'h1234_5678.
   - Required: all outputs stable; req_ready=0; when map_ready=1, the next beat follows in the same cycle.
4. Disabled entry.
   - Stimulus: entry 1 enable=0; source 1 valid.
   - Required: req_ready[1] stays 0 for 20 cycles; the other sources are granted normally.
5. Config collision.
   - Stimulus: write entry 0 contract 32'hBEEF in the same cycle as a grant to 0 (old value 32'hCAFE).
   - Required: the issued beat carries 32'hCAFE; the next beat from source 0 carries 32'hBEEF.
6. Reset mid-stall.
   - Stimulus: assert rst_n low while map_valid=1 and map_ready=0.
   - Required: map_valid=0 immediately; after release, the table is cleared and no grants occur until an entry is re-enabled.

Source files
------------

// File: rtl/xenoa_sched_pkg.sv
// Shared types and constants for the xenoa boundary scheduler.
// A boundary context is one table entry; a semantic beat is the per-source payload.
package xenoa_sched_pkg;

    localparam logic [7:0] BT_RACK    = 8'd0;
    localparam logic [7:0] BT_CLUSTER = 8'd1;
    localparam logic [7:0] BT_DOMAIN  = 8'd2;
    localparam logic [7:0] BT_TENANT  = 8'd3;

    typedef struct packed {
        logic [15:0] boundary_id;
        logic [7:0]  boundary_type;
        logic [31:0] contract_id;
        logic [31:0] sla_id;
        logic        enable;
    } boundary_ctx_t;

    typedef struct packed {
        logic [31:0]  key;
        logic [31:0]  value;
        logic [3:0]   severity;
        logic [127:0] chain;
    } sem_beat_t;

endpackage

// File: rtl/xenoa_rr_arbiter.sv
// Round-robin priority pick: first eligible index at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module xenoa_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && elig[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/xenoa_boundary_sched.sv
// Shares one boundary-mapping stage among NUM_REQ sources: round-robin with a
// per-source burst limit, a per-source context table and one registered output slot.
module xenoa_boundary_sched
    import xenoa_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_key,
    input  logic [NUM_REQ*32-1:0]  req_value,
    input  logic [NUM_REQ*4-1:0]   req_severity,
    input  logic [NUM_REQ*128-1:0] req_chain,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [15:0]            cfg_boundary_id,
    input  logic [7:0]             cfg_boundary_type,
    input  logic [31:0]            cfg_contract_id,
    input  logic [31:0]            cfg_sla_id,
    input  logic                   cfg_enable,
    output logic                   map_valid,
    input  logic                   map_ready,
    output logic [15:0]            map_boundary_id,
    output logic [7:0]             map_boundary_type,
    output logic [31:0]            map_contract_id,
    output logic [31:0]            map_sla_id,
    output logic [31:0]            map_key,
    output logic [31:0]            map_value,
    output logic [3:0]             map_severity,
    output logic [127:0]           map_chain,
    output logic [IDX_W-1:0]       map_src,
    output logic                   busy
);

    localparam logic [3:0]         MB       = 4'(MAX_BURST);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    boundary_ctx_t        tbl [NUM_REQ];
    sem_beat_t            slot;
    sem_beat_t            beat_sel;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     last_src;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     ptr_after;
    logic [3:0]           burst_cnt;
    logic [3:0]           burst_nxt;
    logic                 slot_free;
    logic                 keep;
    logic                 grant;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) elig[i] = req_valid[i] & tbl[i].enable;
    end

    xenoa_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .elig    (elig),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // A nonzero burst count means the previous slot-free cycle granted last_src.
    assign slot_free = !map_valid || map_ready;
    assign keep      = slot_free && elig[last_src] && (burst_cnt != 4'd0) && (burst_cnt < MB);
    assign grant     = slot_free && (keep || (pick_any && (pick_gnt != '0)));
    assign gnt_idx   = keep ? last_src : pick_idx;
    assign burst_nxt = keep ? burst_cnt + 4'd1 : 4'd1;
    assign ptr_after = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    assign req_ready = grant ? (ONE << gnt_idx) : '0;
    assign busy      = map_valid | (|elig);

    always_comb begin
        beat_sel.key      = req_key[32*gnt_idx +: 32];
        beat_sel.value    = req_value[32*gnt_idx +: 32];
        beat_sel.severity = req_severity[4*gnt_idx +: 4];
        beat_sel.chain    = req_chain[128*gnt_idx +: 128];
    end

    // Table reads are combinational from the registers, so a same-cycle write is not seen by the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) tbl[i] <= '0;
        end else if (cfg_we && (int'(cfg_idx) < NUM_REQ)) begin
            tbl[cfg_idx] <= '{boundary_id:   cfg_boundary_id,
                              boundary_type: cfg_boundary_type,
                              contract_id:   cfg_contract_id,
                              sla_id:        cfg_sla_id,
                              enable:        cfg_enable};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_valid         <= 1'b0;
            slot              <= '0;
            map_boundary_id   <= '0;
            map_boundary_type <= '0;
            map_contract_id   <= '0;
            map_sla_id        <= '0;
            map_src           <= '0;
            rr_ptr            <= '0;
            last_src          <= '0;
            burst_cnt         <= '0;
        end else if (slot_free) begin
            if (grant) begin
                map_valid         <= 1'b1;
                slot              <= beat_sel;
                map_boundary_id   <= tbl[gnt_idx].boundary_id;
                map_boundary_type <= tbl[gnt_idx].boundary_type;
                map_contract_id   <= tbl[gnt_idx].contract_id;
                map_sla_id        <= tbl[gnt_idx].sla_id;
                map_src           <= gnt_idx;
                last_src          <= gnt_idx;
                burst_cnt         <= burst_nxt;
                if (!keep || burst_nxt == MB) rr_ptr <= ptr_after;
            end else begin
                map_valid <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

    assign map_key      = slot.key;
    assign map_value    = slot.value;
    assign map_severity = slot.severity;
    assign map_chain    = slot.chain;

endmodule

// File: tb/tb_xenoa_boundary_sched.sv
// Bench for xenoa_boundary_sched: directed vector tables, corner sequences and
// randomized traffic against a queue-free behavioural scheduler model.
module tb_xenoa_boundary_sched;

    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]     req_valid;
    logic [N*32-1:0]  req_key, req_value;
    logic [N*4-1:0]   req_severity;
    logic [N*128-1:0] req_chain;
    logic             cfg_we, cfg_enable, map_ready;
    logic [1:0]       cfg_idx;
    logic [15:0]      cfg_boundary_id;
    logic [7:0]       cfg_boundary_type;
    logic [31:0]      cfg_contract_id, cfg_sla_id;

    logic [N-1:0]  req_ready, s1_ready;
    logic          map_valid, s1_valid, busy, s1_busy;
    logic [15:0]   map_boundary_id, s1_bid;
    logic [7:0]    map_boundary_type, s1_btype;
    logic [31:0]   map_contract_id, map_sla_id, map_key, map_value;
    logic [31:0]   s1_contract, s1_sla, s1_key, s1_value;
    logic [3:0]    map_severity, s1_sev;
    logic [127:0]  map_chain, s1_chain;
    logic [1:0]    map_src, s1_src;

    xenoa_boundary_sched #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_value(req_value), .req_severity(req_severity), .req_chain(req_chain),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_boundary_id(cfg_boundary_id),
        .cfg_boundary_type(cfg_boundary_type), .cfg_contract_id(cfg_contract_id),
        .cfg_sla_id(cfg_sla_id), .cfg_enable(cfg_enable),
        .map_valid(map_valid), .map_ready(map_ready), .map_boundary_id(map_boundary_id),
        .map_boundary_type(map_boundary_type), .map_contract_id(map_contract_id),
        .map_sla_id(map_sla_id), .map_key(map_key), .map_value(map_value),
        .map_severity(map_severity), .map_chain(map_chain), .map_src(map_src), .busy(busy)
    );

    xenoa_boundary_sched #(.NUM_REQ(N), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s1_ready),
        .req_key(req_key), .req_value(req_value), .req_severity(req_severity), .req_chain(req_chain),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_boundary_id(cfg_boundary_id),
        .cfg_boundary_type(cfg_boundary_type), .cfg_contract_id(cfg_contract_id),
        .cfg_sla_id(cfg_sla_id), .cfg_enable(cfg_enable),
        .map_valid(s1_valid), .map_ready(map_ready), .map_boundary_id(s1_bid),
        .map_boundary_type(s1_btype), .map_contract_id(s1_contract),
        .map_sla_id(s1_sla), .map_key(s1_key), .map_value(s1_value),
        .map_severity(s1_sev), .map_chain(s1_chain), .map_src(s1_src), .busy(s1_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_key = '0; req_value = '0; req_severity = '0; req_chain = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_boundary_id = '0; cfg_boundary_type = '0;
        cfg_contract_id = '0; cfg_sla_id = '0; cfg_enable = 1'b0; map_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int idx, input logic [15:0] id, input logic [7:0] bt,
                             input logic [31:0] ct, input logic [31:0] sla, input logic en);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_boundary_id = id; cfg_boundary_type = bt;
        cfg_contract_id = ct; cfg_sla_id = sla; cfg_enable = en;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic config_all(input logic [N-1:0] en);
        for (int i = 0; i < N; i++)
            cfg_write(i, 16'h0A00 + 16'(i), 8'(i), 32'hC000 + 32'(i), 32'h5000 + 32'(i), en[i]);
    endtask

    task automatic set_keys();
        for (int i = 0; i < N; i++) req_key[32*i +: 32] = 32'h1000 + 32'(i);
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [1:0]   exp_src;
        logic [15:0]  exp_bid;
    } vec_t;

    vec_t v_rr [5];
    vec_t v_burst [9];

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [15:0] id; logic [7:0] bt; logic [31:0] ct; logic [31:0] sla; logic en;
    } mctx_t;
    mctx_t        mtab [N];
    logic         m_mv;
    logic [31:0]  m_key, m_val;
    logic [3:0]   m_sev;
    logic [127:0] m_chain;
    int           m_src, m_last, m_cnt, m_ptr;
    mctx_t        m_ctx;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mtab[i] = '{16'h0, 8'h0, 32'h0, 32'h0, 1'b0};
        m_mv = 1'b0; m_key = '0; m_val = '0; m_sev = '0; m_chain = '0;
        m_src = 0; m_last = 0; m_cnt = 0; m_ptr = 0; m_ctx = mtab[0];
    endtask

    task automatic model_step();
        logic free, keep, any_elig;
        int g;
        logic [N-1:0] exp_rdy;
        free = !m_mv || map_ready;
        keep = 1'b0;
        g = -1;
        any_elig = 1'b0;
        for (int i = 0; i < N; i++) if (req_valid[i] && mtab[i].en) any_elig = 1'b1;
        if (free) begin
            if (m_cnt > 0 && m_cnt < MB && req_valid[m_last] && mtab[m_last].en) begin
                g = m_last; keep = 1'b1;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N] && mtab[(m_ptr + k) % N].en)
                        g = (m_ptr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? N'(1) << g : '0;
        check("rand_ready", 256'(req_ready), 256'(exp_rdy));
        check("rand_valid", 256'(map_valid), 256'(m_mv));
        check("rand_busy", 256'(busy), 256'(m_mv || any_elig));
        if (m_mv) begin
            check("rand_slot",
                  {map_src, map_boundary_id, map_boundary_type, map_contract_id, map_sla_id,
                   map_key, map_value, map_severity},
                  {2'(m_src), m_ctx.id, m_ctx.bt, m_ctx.ct, m_ctx.sla, m_key, m_val, m_sev});
            check("rand_chain", 256'(map_chain), 256'(m_chain));
        end
        // state advance for the coming edge
        if (free) begin
            if (g >= 0) begin
                m_mv = 1'b1; m_src = g; m_ctx = mtab[g];
                m_key = req_key[32*g +: 32]; m_val = req_value[32*g +: 32];
                m_sev = req_severity[4*g +: 4]; m_chain = req_chain[128*g +: 128];
                m_cnt = keep ? m_cnt + 1 : 1;
                if (!keep || m_cnt == MB) m_ptr = (g + 1) % N;
                m_last = g;
            end else begin
                m_mv = 1'b0; m_cnt = 0;
            end
        end
        if (cfg_we)
            mtab[cfg_idx] = '{cfg_boundary_id, cfg_boundary_type, cfg_contract_id, cfg_sla_id, cfg_enable};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] seen;
        idle_inputs();

        for (int k = 0; k < 5; k++) v_rr[k] = '{4'hF, 2'(k % 4), 16'h0A00 + 16'(k % 4)};
        v_burst[0] = '{4'b0101, 2'd0, 16'h0A00};
        v_burst[1] = '{4'b0101, 2'd0, 16'h0A00};
        v_burst[2] = '{4'b0101, 2'd0, 16'h0A00};
        v_burst[3] = '{4'b0101, 2'd0, 16'h0A00};
        v_burst[4] = '{4'b0101, 2'd2, 16'h0A02};
        v_burst[5] = '{4'b0101, 2'd2, 16'h0A02};
        v_burst[6] = '{4'b0101, 2'd2, 16'h0A02};
        v_burst[7] = '{4'b0101, 2'd2, 16'h0A02};
        v_burst[8] = '{4'b0101, 2'd0, 16'h0A00};

        // reset state
        do_reset();
        #1;
        check("reset_outputs", {map_valid, map_key, map_src, req_ready, busy, map_contract_id}, '0);

        // round robin with burst limit 1
        config_all(4'hF);
        set_keys();
        map_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = v_rr[k].valid;
            @(negedge clk);
            check($sformatf("rr_beat%0d", k), {s1_valid, s1_src, s1_bid, s1_key},
                  {1'b1, v_rr[k].exp_src, v_rr[k].exp_bid, 32'h1000 + 32'(v_rr[k].exp_src)});
        end

        // burst limit 4, sources 0 and 2
        do_reset();
        config_all(4'hF);
        set_keys();
        map_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            req_valid = v_burst[k].valid;
            @(negedge clk);
            check($sformatf("burst_beat%0d", k), {map_valid, map_src, map_boundary_id},
                  {1'b1, v_burst[k].exp_src, v_burst[k].exp_bid});
        end

        // backpressure
        do_reset();
        config_all(4'hF);
        req_key[31:0] = 32'h1234_5678;
        req_valid = 4'b0001;
        map_ready = 1'b0;
        @(negedge clk);
        req_key[31:0] = 32'hAAAA_0001;
        req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d", k), {map_valid, map_src, map_key, map_boundary_id, req_ready},
                  {1'b1, 2'd0, 32'h1234_5678, 16'h0A00, 4'b0000});
            @(negedge clk);
        end
        map_ready = 1'b1;
        #1;
        check("stall_release_ready", 256'(req_ready), 256'(4'b0001));
        @(negedge clk);
        check("stall_next_beat", {map_valid, map_src, map_key}, {1'b1, 2'd0, 32'hAAAA_0001});

        // disabled entry
        do_reset();
        config_all(4'b1101);
        req_valid = 4'hF;
        map_ready = 1'b1;
        seen = '0;
        for (int k = 0; k < 20; k++) begin
            #1;
            check($sformatf("disabled_ready%0d", k), 256'(req_ready[1]), 256'(1'b0));
            @(negedge clk);
            if (map_valid) seen[map_src] = 1'b1;
        end
        check("disabled_seen", 256'(seen), 256'(4'b1101));

        // config write colliding with a grant
        do_reset();
        cfg_write(0, 16'h0A00, 8'h07, 32'h0000_CAFE, 32'h5000, 1'b1);
        req_valid = 4'b0001;
        map_ready = 1'b1;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_boundary_id = 16'h0A00; cfg_boundary_type = 8'h07;
        cfg_contract_id = 32'h0000_BEEF; cfg_sla_id = 32'h5000; cfg_enable = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        check("collide_old", {map_valid, map_contract_id, map_boundary_type}, {1'b1, 32'h0000_CAFE, 8'h07});
        @(negedge clk);
        check("collide_new", {map_valid, map_contract_id}, {1'b1, 32'h0000_BEEF});

        // reset while stalled
        do_reset();
        config_all(4'b0001);
        req_valid = 4'b0001;
        map_ready = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 256'(map_valid), 256'(1'b1));
        #2 rst_n = 1'b0;
        #1 check("async_reset_valid", {map_valid, map_key, map_contract_id}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'hF;
        map_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", k), {map_valid, req_ready, busy}, '0);
        end
        cfg_write(2, 16'h0B02, 8'd2, 32'hD002, 32'h6002, 1'b1);
        #1;
        check("reenable_ready", 256'(req_ready), 256'(4'b0100));
        @(negedge clk);
        check("reenable_grant", {map_valid, map_src, map_boundary_id}, {1'b1, 2'd2, 16'h0B02});

        // randomized traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_key[32*i +: 32]    = $urandom;
                req_value[32*i +: 32]  = $urandom;
                req_severity[4*i +: 4] = 4'($urandom);
                req_chain[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            end
            map_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_idx = 2'($urandom);
            cfg_boundary_id = 16'($urandom);
            cfg_boundary_type = 8'($urandom);
            cfg_contract_id = $urandom;
            cfg_sla_id = $urandom;
            cfg_enable = ($urandom_range(0, 3) != 0);
            #1;
            model_step();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
